mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide responder for the P6 pipeline.
- The E-stage issues a one-cycle `start` with an op and two 32-bit operands; the unit goes busy for a fixed latency, then commits HI/LO.
- The stall controller (initiator) watches `busy` and `start` to freeze D-stage MDU instructions.
- MFHI/MFLO read `hi`/`lo` directly; MTHI/MTLO write them when the unit is idle.

Parameters:
- MULT_LAT, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_LAT, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle op request from E-stage.
- op  input  3  operation code; encodings in mdu_pkg.
- a  input  32  operand rs.
- b  input  32  operand rt.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse on the cycle HI/LO commit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset mid-operation aborts the op; there is no commit.
- States: IDLE, BUSY.
- IDLE, start=1 with op in {MULT, MULTU, DIV, DIVU}:
  - Compute the result into an internal 64-bit holding register at this edge.
  - Load counter = LAT-1 and go to BUSY.
  - busy=1 from the next cycle.
- BUSY: counter decrements each cycle.
  - When counter==0: write hi/lo from the holding register, pulse done=1, return to IDLE.
  - busy=0 on the cycle done=1.
  - Total: busy is high for exactly LAT cycles after the start edge.
- IDLE, start=1 with op MTHI/MTLO: write hi=a or lo=a at that edge. No busy, no done.
- start=1 while BUSY: ignored (not queued). The stall logic guarantees it never occurs; the bench checks it is harmless.
- Unused op codes: ignored.
- MULT: {hi,lo} = signed(a)*signed(b). MULTU: unsigned, 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0): full latency is still spent and done pulses, but hi/lo keep their prior values.
- hi/lo change only at a commit edge or an MTHI/MTLO edge. During BUSY they hold their old values.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds op codes MADD/MADDU: {hi,lo} = {hi,lo} + product (signed/unsigned), modulo 2^64.
  - Uses MULT_LAT.
  - Accumulates against the {hi,lo} value present at the start edge.
- Undefined:
  - MADD/MADDU codes are treated as unused and ignored.
  - No accumulate adder is synthesised.

Decomposition:
- mdu_pkg holds:
  - Op encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MADD=6, MDU_MADDU=7.
  - State encodings IDLE/BUSY.
  - Default latencies.
- No sub-module is required. Arithmetic is behavioural (`*`, `/`, `%`) and the latency counter is inline.

Test Plan:
- Reset then idle: hi=lo=0, busy=0; MTHI a=0x12345678 → next cycle hi=0x12345678, busy stays 0.
- MULT a=0xFFFFFFFE(-2), b=3:
  - busy high exactly 5 cycles; done pulses once.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - hi/lo unchanged while busy.
- DIV a=0xFFFFFFF9(-7), b=2 → after 10 busy cycles lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU same operands → lo=0x7FFFFFFC, hi=1.
- DIV with b=0, prior hi=0xA, lo=0xB → busy 10 cycles, done pulses, hi=0xA, lo=0xB. Second start asserted mid-BUSY is ignored.
- Reset_n pulsed low on 3rd busy cycle of MULTU a=b=0xFFFFFFFF → busy drops immediately, hi=lo=0, no done pulse.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 → hi=1, lo=0 after 5 cycles. Without it, the same op leaves state untouched.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM state type and default latencies shared by
// the multiply/divide unit and anything that drives it.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;
    localparam logic [2:0] MDU_MADDU = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int MDU_MULT_LAT_DEF = 5;
    localparam int MDU_DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide responder with HI/LO registers.
// The result is computed at the start edge into a holding register and
// committed to HI/LO after a fixed latency. Optional multiply-accumulate
// ops (MADD/MADDU) are built only when MDU_MADD_EN is defined.
import mdu_pkg::*;

module mdu_unit #(
    parameter int MULT_LAT = MDU_MULT_LAT_DEF,
    parameter int DIV_LAT  = MDU_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [63:0]      hold;
    logic             commit;

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] sdiv_den;
    logic [31:0] udiv_den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] sdiv_q;
    logic [31:0] sdiv_r;
    logic [31:0] udiv_q;
    logic [31:0] udiv_r;

    // Products and quotients for the operands on the bus; signed division
    // works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    always_comb begin
        a_ext         = {{32{a[31]}}, a};
        b_ext         = {{32{b[31]}}, b};
        prod_signed   = a_ext * b_ext;
        prod_unsigned = {32'd0, a} * {32'd0, b};
        a_neg         = a[31];
        b_neg         = b[31];
        a_mag         = a_neg ? (~a + 32'd1) : a;
        b_mag         = b_neg ? (~b + 32'd1) : b;
        sdiv_den      = (b == 32'd0) ? 32'd1 : b_mag;
        udiv_den      = (b == 32'd0) ? 32'd1 : b;
        q_mag         = a_mag / sdiv_den;
        r_mag         = a_mag % sdiv_den;
        sdiv_q        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        sdiv_r        = a_neg ? (~r_mag + 32'd1) : r_mag;
        udiv_q        = a / udiv_den;
        udiv_r        = a % udiv_den;
    end

    // Control FSM: latch a result on start, count the latency down, then
    // commit HI/LO (unless the op was a divide by zero) and pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            counter <= '0;
            hold    <= 64'd0;
            commit  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MULT: begin
                                hold    <= prod_signed;
                                commit  <= 1'b1;
                                counter <= MULT_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MDU_MULTU: begin
                                hold    <= prod_unsigned;
                                commit  <= 1'b1;
                                counter <= MULT_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MDU_DIV: begin
                                hold    <= {sdiv_r, sdiv_q};
                                commit  <= (b != 32'd0);
                                counter <= DIV_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MDU_DIVU: begin
                                hold    <= {udiv_r, udiv_q};
                                commit  <= (b != 32'd0);
                                counter <= DIV_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
`ifdef MDU_MADD_EN
                            MDU_MADD: begin
                                hold    <= {hi, lo} + prod_signed;
                                commit  <= 1'b1;
                                counter <= MULT_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
                            MDU_MADDU: begin
                                hold    <= {hi, lo} + prod_unsigned;
                                commit  <= 1'b1;
                                counter <= MULT_CNT;
                                busy    <= 1'b1;
                                state   <= BUSY;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (counter == '0) begin
                        if (commit) begin
                            {hi, lo} <= hold;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: scoreboard bench for mdu_unit. Stimulus pushes expected
// HI/LO/latency per op; a monitor checks on every done pulse and checks
// HI/LO hold steady while busy. Honours MDU_MADD_EN like the RTL.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          busy_run = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_output({name, "_timeout"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic apply_stimulus(input string name, input logic [2:0] o,
                                  input logic [31:0] va, input logic [31:0] vb,
                                  input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                  input int lat);
        exp_t e;
        e.hi = exp_hi; e.lo = exp_lo; e.old_hi = model_hi; e.old_lo = model_lo;
        e.lat = lat; e.name = name;
        sb.push_back(e);
        model_hi = exp_hi;
        model_lo = exp_lo;
        issue(o, va, vb);
        wait_idle(name);
    endtask

    // Monitor: checks HI/LO hold while busy and the committed result on done
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_run = 0;
            end else begin
                if (busy) begin
                    busy_run++;
                    if (sb.size() > 0) begin
                        check_output({sb[0].name, "_hold_hi"}, hi, sb[0].old_hi);
                        check_output({sb[0].name, "_hold_lo"}, lo, sb[0].old_lo);
                    end
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_done: got done=1, expected done=0");
                    end else begin
                        e = sb.pop_front();
                        check_output({e.name, "_hi"}, hi, e.hi);
                        check_output({e.name, "_lo"}, lo, e.lo);
                        check_output({e.name, "_busy_cycles"}, 32'(busy_run), 32'(e.lat));
                        check_output({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
                    end
                    busy_run = 0;
                end
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_output("reset_hi", hi, 32'd0);
        check_output("reset_lo", lo, 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);

        issue(MDU_MTHI, 32'h1234_5678, 32'd0);
        check_output("mthi_hi", hi, 32'h1234_5678);
        check_output("mthi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check_output("mthi_busy_next", 32'(busy), 32'd0);
        check_output("mthi_lo", lo, 32'd0);
        model_hi = 32'h1234_5678;

        apply_stimulus("mult_neg", MDU_MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        apply_stimulus("div_neg",  MDU_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        apply_stimulus("divu",     MDU_DIVU,  32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 10);
        apply_stimulus("div_ovf",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        apply_stimulus("div_pos_neg", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        apply_stimulus("mult_min", MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5);
        apply_stimulus("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);

        issue(MDU_MTHI, 32'h0000_000A, 32'd0);
        issue(MDU_MTLO, 32'h0000_000B, 32'd0);
        model_hi = 32'h0000_000A;
        model_lo = 32'h0000_000B;

        e.hi = 32'hA; e.lo = 32'hB; e.old_hi = 32'hA; e.old_lo = 32'hB;
        e.lat = 10; e.name = "div_zero";
        sb.push_back(e);
        issue(MDU_DIV, 32'd5, 32'd0);
        repeat (3) @(negedge clk);
        issue(MDU_MTHI, 32'h0000_DEAD, 32'd0);
        issue(MDU_MULT, 32'd2, 32'd3);
        wait_idle("div_zero");
        repeat (8) @(negedge clk);
        check_output("ignored_start_busy", 32'(busy), 32'd0);
        check_output("ignored_start_hi", hi, 32'h0000_000A);
        check_output("ignored_start_lo", lo, 32'h0000_000B);

        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFF_FFFF, 32'd0);
        model_hi = 32'd0;
        model_lo = 32'hFFFF_FFFF;
`ifdef MDU_MADD_EN
        apply_stimulus("maddu", MDU_MADDU, 32'd1, 32'd1, 32'h0000_0001, 32'h0000_0000, 5);
        apply_stimulus("madd",  MDU_MADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'hFFFF_FFFF, 5);
`else
        issue(MDU_MADDU, 32'd1, 32'd1);
        for (int i = 0; i < 7; i++) begin
            check_output("maddu_off_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        check_output("maddu_off_hi", hi, 32'd0);
        check_output("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        check_output("abort_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_hi", hi, 32'd0);
        check_output("abort_lo", lo, 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_output("post_abort_busy", 32'(busy), 32'd0);
        check_output("post_abort_hi", hi, 32'd0);
        check_output("post_abort_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
